// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the multiply/divide unit: word size, RISC-V M
// funct3 encodings and the controller state type.
package muldiv_unit_pkg;

  localparam int WORD_SIZE = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } stateT;

  // Remainder ops return the dividend-side result.
  function automatic logic isRemOp(input logic [2:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_unit_div.sv
// Iterative datapath shared by restoring divide and shift-add multiply.
// Operates on magnitudes; the sign correction is applied on the output.
module div_iter
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = WORD_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            isMul,
  input  logic            selHi,
  input  logic            signFix,
  input  logic [XLEN-1:0] aMag,
  input  logic [XLEN-1:0] bMag,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0]   acc;       // remainder (divide) / product high half (multiply)
  logic [XLEN-1:0]   quo;       // quotient (divide) / multiplier then product low half
  logic [XLEN-1:0]   bReg;      // divisor / multiplicand
  logic              isMulQ;
  logic              selHiQ;
  logic              signFixQ;

  logic [XLEN:0]     shifted;
  logic [XLEN-1:0]   diffLo;
  logic              geq;
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] product;
  logic [2*XLEN-1:0] prodFix;
  logic [XLEN-1:0]   quoFix;
  logic [XLEN-1:0]   remFix;

  // One iteration of either algorithm, computed from the current registers.
  // NOTE: every variable in a combinational block gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    shifted = {acc, quo[XLEN-1]};
    diffLo  = shifted[XLEN-1:0] - bReg;
    geq     = (shifted >= {1'b0, bReg});
    sum     = {1'b0, acc} + (quo[0] ? {1'b0, bReg} : '0);
  end

  // Load operands on accept, then advance one bit per step.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: datapath registers are reset as well, so a discarded operation leaves nothing behind.
      acc      <= '0;
      quo      <= '0;
      bReg     <= '0;
      isMulQ   <= 1'b0;
      selHiQ   <= 1'b0;
      signFixQ <= 1'b0;
    end else if (load) begin
      acc      <= '0;
      quo      <= aMag;
      bReg     <= bMag;
      isMulQ   <= isMul;
      selHiQ   <= selHi;
      signFixQ <= signFix;
    end else if (step) begin
      if (isMulQ) begin
        acc <= sum[XLEN:1];
        quo <= {sum[0], quo[XLEN-1:1]};
      end else begin
        acc <= geq ? diffLo : shifted[XLEN-1:0];
        quo <= {quo[XLEN-2:0], geq};
      end
    end
  end

  // Sign-corrected result selection, consumed by the controller in FIX.
  always_comb begin
    product = {acc, quo};
    prodFix = signFixQ ? -product : product;
    quoFix  = signFixQ ? -quo : quo;
    remFix  = signFixQ ? -acc : acc;
    if (isMulQ) result = selHiQ ? prodFix[2*XLEN-1:XLEN] : prodFix[XLEN-1:0];
    else        result = selHiQ ? remFix : quoFix;
  end

endmodule

// File: rtl/muldiv_unit.sv
// RISC-V M-extension multiply/divide unit. Single-step multiply (optional),
// iterative divide / multiply via div_iter, early-out for divide by zero
// and signed overflow. Stalls the pipeline through MulH while busy.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN     = WORD_SIZE,
  parameter int FAST_MUL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StartE,
  input  logic [2:0]      OpE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic [4:0]      RdE,
  input  logic            FlushE,
  output logic            MulH,
  output logic            DoneM,
  output logic [XLEN-1:0] ResultM,
  output logic [4:0]      RdM
);

  localparam bit              FastMul  = (FAST_MUL != 0);
  localparam logic [XLEN-1:0] LastIter = XLEN'(XLEN - 1);
  localparam logic [XLEN-1:0] MinNeg   = {1'b1, {(XLEN-1){1'b0}}};

  stateT state, stateNext;

  logic [XLEN-1:0]   iterCnt;
  logic [4:0]        rdQ;
  logic              accept;
  logic              loadIter;
  logic              stepIter;
  logic [XLEN-1:0]   iterResult;

  logic              isMul, isRem, aSigned, bSigned, aNeg, bNeg;
  logic              selHi, signFix, divZero, overflow, singleStep;
  logic [XLEN-1:0]   aMag, bMag;
  logic [2*XLEN-1:0] fastProd, fastProdFix;
  logic [XLEN-1:0]   fastResult;

  // Decode the incoming request into magnitudes, sign flags and early-outs.
  always_comb begin
    isMul    = ~OpE[2];
    isRem    = isRemOp(OpE);
    aSigned  = (OpE == OP_MULH) || (OpE == OP_MULHSU) || (OpE == OP_DIV) || (OpE == OP_REM);
    bSigned  = (OpE == OP_MULH) || (OpE == OP_DIV) || (OpE == OP_REM);
    aNeg     = aSigned & SrcAE[XLEN-1];
    bNeg     = bSigned & SrcBE[XLEN-1];
    aMag     = aNeg ? -SrcAE : SrcAE;
    bMag     = bNeg ? -SrcBE : SrcBE;
    selHi    = isMul ? (OpE != OP_MUL) : isRem;
    signFix  = isRem ? aNeg : (aNeg ^ bNeg);
    divZero  = ~isMul && (SrcBE == '0);
    overflow = ((OpE == OP_DIV) || (OpE == OP_REM)) && (SrcAE == MinNeg) && (SrcBE == '1);
    singleStep = (isMul && FastMul) || divZero || overflow;
  end

  // Single-step results: full multiply, divide-by-zero and overflow values.
  always_comb begin
    fastProd    = {{XLEN{1'b0}}, aMag} * {{XLEN{1'b0}}, bMag};
    fastProdFix = signFix ? -fastProd : fastProd;
    fastResult  = selHi ? fastProdFix[2*XLEN-1:XLEN] : fastProdFix[XLEN-1:0];
    if (divZero)       fastResult = isRem ? SrcAE : '1;
    else if (overflow) fastResult = isRem ? '0 : MinNeg;
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // Next state and control outputs.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    loadIter  = 1'b0;
    stepIter  = 1'b0;
    DoneM     = 1'b0;
    MulH      = 1'b0;
    unique case (state)
      IDLE: begin
        accept   = StartE && !FlushE;
        loadIter = accept && !singleStep;
        MulH     = StartE && !singleStep;
        if (accept) stateNext = singleStep ? DONE : RUN;
      end
      RUN: begin
        MulH     = 1'b1;
        stepIter = !FlushE;
        if (FlushE)                  stateNext = IDLE;
        else if (iterCnt == LastIter) stateNext = FIX;
      end
      FIX: begin
        MulH      = 1'b1;
        stateNext = FlushE ? IDLE : DONE;
      end
      DONE: begin
        DoneM     = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    MulH = MulH && rst;
  end

  // Iteration counter: cleared on load, counts RUN cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  iterCnt <= '0;
    else if (loadIter)         iterCnt <= '0;
    else if (state == RUN)     iterCnt <= iterCnt + XLEN'(1);
  end

  // Result and tag registers; they hold until the next completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ResultM <= '0;
      RdM     <= '0;
      rdQ     <= '0;
    end else begin
      if (loadIter) rdQ <= RdE;
      if (accept && singleStep) begin
        ResultM <= fastResult;
        RdM     <= RdE;
      end else if ((state == FIX) && !FlushE) begin
        ResultM <= iterResult;
        RdM     <= rdQ;
      end
    end
  end

  div_iter #(.XLEN(XLEN)) uDivIter (
    .clk     (clk),
    .rst     (rst),
    .load    (loadIter),
    .step    (stepIter),
    .isMul   (isMul),
    .selHi   (selHi),
    .signFix (signFix),
    .aMag    (aMag),
    .bMag    (bMag),
    .result  (iterResult)
  );

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (XLEN=32, FAST_MUL=1).
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        StartE;
  logic [2:0]  OpE;
  logic [31:0] SrcAE, SrcBE;
  logic [4:0]  RdE;
  logic        FlushE;
  logic        MulH, DoneM;
  logic [31:0] ResultM;
  logic [4:0]  RdM;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } expT;

  expT         sbQ[$];
  int          vecCount = 0;
  int          errCount = 0;
  logic [31:0] lastRes;

  muldiv_unit #(.XLEN(32), .FAST_MUL(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .StartE  (StartE),
    .OpE     (OpE),
    .SrcAE   (SrcAE),
    .SrcBE   (SrcBE),
    .RdE     (RdE),
    .FlushE  (FlushE),
    .MulH    (MulH),
    .DoneM   (DoneM),
    .ResultM (ResultM),
    .RdM     (RdM)
  );

  always #5 clk = ~clk;

  // Reference model using native SV arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_MUL:    begin p = sa * sb; return p[31:0]; end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Completion monitor: every DoneM must match the oldest expected entry.
  always @(negedge clk) begin : monitor
    expT e;
    if (rst && DoneM) begin
      if (sbQ.size() == 0) begin
        vecCount++; errCount++;
        $display("FAIL unexpected_done: DoneM=1 ResultM=%h, required no completion", ResultM);
      end else begin
        e = sbQ.pop_front();
        vecCount++;
        if (ResultM !== e.res) begin
          errCount++;
          $display("FAIL result: got %h, expected %h", ResultM, e.res);
        end
        vecCount++;
        if (RdM !== e.rd) begin
          errCount++;
          $display("FAIL rd_tag: got %0d, expected %0d", RdM, e.rd);
        end
      end
    end
  end

  // Issue one request, optionally poke StartE at cycle pokeCyc, check latency and stall length.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int pokeCyc);
    int   expLat, expMulH, mulHCnt, doneCyc;
    logic single;
    expT  e;
    single  = (op[2] == 1'b0) || (b == 0) ||
              (((op == OP_DIV) || (op == OP_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
    expLat  = single ? 1 : 34;
    expMulH = single ? 0 : 34;
    e.res   = model(op, a, b);
    e.rd    = rd;
    lastRes = e.res;
    sbQ.push_back(e);
    mulHCnt = 0;
    doneCyc = -1;
    @(posedge clk); #1;
    StartE = 1'b1; OpE = op; SrcAE = a; SrcBE = b; RdE = rd;
    @(negedge clk);
    if (MulH) mulHCnt++;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      StartE = (c == pokeCyc);
      OpE    = (c == pokeCyc) ? OP_MUL : 3'($urandom);
      SrcAE  = $urandom;
      SrcBE  = $urandom | 32'h1;
      RdE    = 5'($urandom);
      @(negedge clk);
      if (MulH) mulHCnt++;
      if (DoneM) begin
        doneCyc = c;
        break;
      end
    end
    @(posedge clk); #1;
    StartE = 1'b0;
    vecCount++;
    if (doneCyc !== expLat) begin
      errCount++;
      $display("FAIL latency op=%0d: DoneM at cycle %0d, expected %0d", op, doneCyc, expLat);
    end
    vecCount++;
    if (mulHCnt !== expMulH) begin
      errCount++;
      $display("FAIL mulh_cycles op=%0d: MulH high %0d cycles, expected %0d", op, mulHCnt, expMulH);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; StartE = 1'b1; OpE = OP_DIV; SrcAE = 32'd9; SrcBE = 32'd2; RdE = 5'd3; FlushE = 1'b0;
    repeat (3) @(negedge clk);
    vecCount++;
    if (DoneM !== 1'b0) begin errCount++; $display("FAIL reset_done: got %b, expected 0", DoneM); end
    vecCount++;
    if (ResultM !== 32'h0) begin errCount++; $display("FAIL reset_result: got %h, expected 0", ResultM); end
    vecCount++;
    if (RdM !== 5'd0) begin errCount++; $display("FAIL reset_rd: got %0d, expected 0", RdM); end
    vecCount++;
    if (MulH !== 1'b0) begin errCount++; $display("FAIL reset_mulh: got %b, expected 0", MulH); end
    StartE = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_mul_fast();
    run_op(OP_MUL,    32'd7,        32'hFFFF_FFFD, 5'd1, 0);
    run_op(OP_MULH,   32'hFFFF_FFF9, 32'd3,        5'd2, 0);
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
    run_op(OP_MULHU,  32'h1234_5678, 32'h9ABC_DEF0, 5'd4, 0);
    run_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd5, 0);
  endtask

  task automatic test_div();
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2,         5'd6, 0);
    run_op(OP_REM,  32'hFFFF_FFF9, 32'd2,         5'd7, 0);
    run_op(OP_DIV,  32'd100,       32'hFFFF_FFF9, 5'd8, 0);
    run_op(OP_REM,  32'd100,       32'hFFFF_FFF9, 5'd9, 0);
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd7,         5'd10, 0);
    run_op(OP_REMU, 32'hDEAD_BEEF, 32'h0001_0003, 5'd11, 0);
  endtask

  task automatic test_div_zero();
    run_op(OP_DIVU, 32'd5,         32'd0, 5'd12, 0);
    run_op(OP_REMU, 32'd5,         32'd0, 5'd13, 0);
    run_op(OP_DIV,  32'hFFFF_FFF0, 32'd0, 5'd14, 0);
    run_op(OP_REM,  32'hFFFF_FFF0, 32'd0, 5'd15, 0);
  endtask

  task automatic test_overflow();
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 0);
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 0);
  endtask

  task automatic test_flush();
    int doneSeen;
    @(posedge clk); #1;
    StartE = 1'b1; OpE = OP_DIVU; SrcAE = 32'd1000; SrcBE = 32'd7; RdE = 5'd18;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      StartE = 1'b0;
      FlushE = (c == 10);
      @(negedge clk);
    end
    vecCount++;
    if (MulH !== 1'b1) begin errCount++; $display("FAIL flush_busy: MulH got %b, expected 1", MulH); end
    @(posedge clk); #1;
    FlushE = 1'b0;
    @(negedge clk);
    vecCount++;
    if (MulH !== 1'b0) begin errCount++; $display("FAIL flush_idle: MulH got %b, expected 0", MulH); end
    doneSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (DoneM) doneSeen++;
    end
    vecCount++;
    if (doneSeen != 0) begin errCount++; $display("FAIL flush_no_done: %0d completions, expected 0", doneSeen); end
    run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd19, 0);
  endtask

  task automatic test_reset_mid();
    int doneSeen;
    @(posedge clk); #1;
    StartE = 1'b1; OpE = OP_DIV; SrcAE = 32'hFFFF_FF00; SrcBE = 32'd3; RdE = 5'd20;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      StartE = 1'b0;
    end
    StartE = 1'b1;
    @(negedge clk);
    vecCount++;
    if (MulH !== 1'b1) begin errCount++; $display("FAIL rstmid_busy: MulH got %b, expected 1", MulH); end
    #1 rst = 1'b0;
    #1;
    vecCount++;
    if (DoneM !== 1'b0) begin errCount++; $display("FAIL rstmid_done: got %b, expected 0", DoneM); end
    vecCount++;
    if (ResultM !== 32'h0) begin errCount++; $display("FAIL rstmid_result: got %h, expected 0", ResultM); end
    vecCount++;
    if (RdM !== 5'd0) begin errCount++; $display("FAIL rstmid_rd: got %0d, expected 0", RdM); end
    vecCount++;
    if (MulH !== 1'b0) begin errCount++; $display("FAIL rstmid_mulh: got %b, expected 0", MulH); end
    @(posedge clk); #1;
    StartE = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    doneSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (DoneM) doneSeen++;
    end
    vecCount++;
    if (doneSeen != 0) begin errCount++; $display("FAIL rstmid_no_done: %0d completions, expected 0", doneSeen); end
  endtask

  task automatic test_back_to_back();
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd21, 3);   // StartE pulsed during RUN
    run_op(OP_MUL, 32'd123,       32'd456, 5'd22, 1); // StartE pulsed during DONE
    repeat (3) @(negedge clk);
    vecCount++;
    if (ResultM !== lastRes) begin errCount++; $display("FAIL result_hold: got %h, expected %h", ResultM, lastRes); end
    for (int i = 0; i < 4; i++)
      run_op(3'($urandom_range(0, 3)), $urandom, $urandom, 5'(23 + i), 0);
    run_op(OP_REMU, $urandom, $urandom | 32'h1, 5'd27, 0);
  endtask

  initial begin
    test_reset();
    test_mul_fast();
    test_div();
    test_div_zero();
    test_overflow();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    repeat (5) @(negedge clk);
    vecCount++;
    if (sbQ.size() != 0) begin errCount++; $display("FAIL drain: %0d completions outstanding, expected 0", sbQ.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width in bits.
REQ-002 SHALL have parameter FAST_MUL, default 1; 1 = single-step multiply, 0 = iterative shift-add multiply.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port StartE  input  1  request from execute stage.
REQ-006 SHALL have port OpE  input  3  operation, RISC-V M funct3 encoding.
REQ-007 SHALL have port SrcAE  input  XLEN  operand A (rs1).
REQ-008 SHALL have port SrcBE  input  XLEN  operand B (rs2).
REQ-009 SHALL have port RdE  input  5  destination register tag.
REQ-010 SHALL have port FlushE  input  1  abort in-flight operation.
REQ-011 SHALL have port MulH  output  1  stall request to hazard unit.
REQ-012 SHALL have port DoneM  output  1  result valid, one-cycle pulse.
REQ-013 SHALL have port ResultM  output  XLEN  result.
REQ-014 SHALL have port RdM  output  5  tag of completed operation.

Function
REQ-015 SHALL use states IDLE, RUN, FIX, DONE.
REQ-016 SHALL accept a request only when StartE=1 in IDLE and FlushE=0; OpE, SrcAE, SrcBE and RdE are captured at that edge.
REQ-017 SHALL ignore StartE in any state other than IDLE.
REQ-018 SHALL decode OpE: 000 MUL (low XLEN), 001 MULH (s*s high), 010 MULHSU (s*u high), 011 MULHU (u*u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-019 SHALL compute signed ops on magnitudes internally and apply sign correction in FIX; product is 2*XLEN bits.
REQ-020 SHALL go IDLE->DONE on accept for multiply when FAST_MUL=1 (DoneM 1 cycle after accept edge).
REQ-021 SHALL go IDLE->RUN for divides and for multiply when FAST_MUL=0: RUN lasts exactly XLEN cycles (one bit per cycle, XLEN-wide iteration counter), then FIX one cycle, then DONE (DoneM XLEN+2 cycles after accept).
REQ-022 SHALL on divide by zero go IDLE->DONE: DIV/DIVU quotient all ones, REM/REMU = SrcAE.
REQ-023 SHALL on signed overflow (SrcAE = most negative, SrcBE = -1) go IDLE->DONE: DIV = most negative, REM = 0.
REQ-024 SHALL set sign: quotient negative iff operand signs differ; remainder takes dividend sign.
REQ-025 SHALL hold DoneM=1 exactly one cycle in DONE with ResultM and RdM valid, then return to IDLE; ResultM/RdM hold value until next DONE.
REQ-026 SHALL drive MulH = (state in {RUN,FIX}) OR (state=IDLE AND StartE=1 AND request not single-step); MulH=0 in DONE so the pipeline advances with the result.
REQ-027 SHALL on FlushE=1 in RUN or FIX return to IDLE next edge with no DoneM; FlushE in DONE does not suppress that cycle's DoneM.
REQ-028 SHALL, if StartE and FlushE are both 1 in IDLE, not accept.

Reset
REQ-029 SHALL on rst=0 asynchronously enter IDLE and clear DoneM=0, ResultM=0, RdM=0, iteration counter=0, internal accumulators=0.
REQ-030 SHALL on reset mid-operation discard the operation with no DoneM after release.
REQ-031 SHALL drive MulH=0 while rst=0.

Structure
REQ-032 SHALL take op encodings (MUL..REMU) and WORD_SIZE from shared constants.v; XLEN defaults to WORD_SIZE.
REQ-033 SHALL place the restoring divide/shift-add datapath in one sub-module div_iter (XLEN parameter, load/step/sign-fix controls); the FSM stays in muldiv_unit.

Verification
REQ-034 SHALL cover: MUL, FAST_MUL=1, A=7, B=-3 -> DoneM 1 cycle later, ResultM=0xFFFFFFEB, MulH=0 throughout.
REQ-035 SHALL cover: DIV A=-7, B=2 -> MulH=1 for 34 cycles, DoneM at cycle 34, ResultM=0xFFFFFFFD; REM same -> 0xFFFFFFFF.
REQ-036 SHALL cover: DIVU A=5, B=0 -> DoneM 1 cycle later, ResultM=0xFFFFFFFF; REMU -> 5.
REQ-037 SHALL cover: DIV A=0x80000000, B=-1 -> ResultM=0x80000000; REM -> 0.
REQ-038 SHALL cover: DIVU started, FlushE at cycle 10 -> IDLE next cycle, no DoneM, new MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-039 SHALL cover: rst=0 at cycle 5 of a DIV -> all outputs 0 immediately, no DoneM after release; StartE during RUN ignored.
